custom_ram_arbiter: RTL and testbench

CUSTOM_RAM_ARBITER -- requirements
Module: custom_ram_arbiter

---
 rtl/ibex_custom_pkg.sv | 13 +
 rtl/custom_ram_arbiter.sv | 100 ++++++++++
 tb/tb_custom_ram_arbiter.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ibex_custom_pkg.sv
// Shared types for the custom-unit RAM arbiter.
// Holds the response-owner encoding and the default RAM address width.
package ibex_custom_pkg;

    localparam int CUSTOM_RAM_ADDR_W = 14;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CUST = 2'd1,
        OWN_LSU  = 2'd2
    } arb_owner_e;

endpackage

// File: rtl/custom_ram_arbiter.sv
// Shares one single-cycle RAM port between the custom unit and the LSU.
// Define CUSTOM_RAM_ARB_STARVE_EN to force the LSU through after MAX_WAIT refusals.
module custom_ram_arbiter
    import ibex_custom_pkg::*;
#(
    parameter int ADDR_W   = CUSTOM_RAM_ADDR_W,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,

    input  logic              cust_req_i,
    input  logic [ADDR_W-1:0] cust_addr_i,
    output logic              cust_gnt_o,
    output logic              cust_rvalid_o,
    output logic [31:0]       cust_rdata_o,

    input  logic              lsu_req_i,
    input  logic              lsu_we_i,
    input  logic [3:0]        lsu_be_i,
    input  logic [ADDR_W-1:0] lsu_addr_i,
    input  logic [31:0]       lsu_wdata_i,
    output logic              lsu_gnt_o,
    output logic              lsu_rvalid_o,
    output logic [31:0]       lsu_rdata_o,

    output logic              ram_req_o,
    output logic              ram_we_o,
    output logic [3:0]        ram_be_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [31:0]       ram_wdata_o,
    input  logic [31:0]       ram_rdata_i
);

    arb_owner_e owner_d, owner_q;
    logic       lsu_force;

`ifdef CUSTOM_RAM_ARB_STARVE_EN
    localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] wait_q;

    // Saturates at the limit; any LSU grant or idle LSU restarts the wait.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_q <= '0;
        end else if (!lsu_req_i || lsu_gnt_o) begin
            wait_q <= '0;
        end else if (wait_q != CNT_MAX) begin
            wait_q <= wait_q + 1'b1;
        end
    end

    assign lsu_force = lsu_req_i & (wait_q == CNT_MAX);
`else
    assign lsu_force = 1'b0;
`endif

    assign cust_gnt_o = cust_req_i & ~lsu_force;
    assign lsu_gnt_o  = lsu_req_i & ~cust_gnt_o;
    assign ram_req_o  = cust_gnt_o | lsu_gnt_o;

    always_comb begin
        ram_we_o    = 1'b0;
        ram_be_o    = 4'h0;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        owner_d     = OWN_NONE;
        unique case (1'b1)
            cust_gnt_o: begin
                ram_be_o   = 4'hF;
                ram_addr_o = cust_addr_i;
                owner_d    = OWN_CUST;
            end
            lsu_gnt_o: begin
                ram_we_o    = lsu_we_i;
                ram_be_o    = lsu_be_i;
                ram_addr_o  = lsu_addr_i;
                ram_wdata_o = lsu_wdata_i;
                owner_d     = OWN_LSU;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    assign cust_rvalid_o = (owner_q == OWN_CUST);
    assign lsu_rvalid_o  = (owner_q == OWN_LSU);
    assign cust_rdata_o  = cust_rvalid_o ? ram_rdata_i : 32'h0;
    assign lsu_rdata_o   = lsu_rvalid_o ? ram_rdata_i : 32'h0;

endmodule

// File: tb/tb_custom_ram_arbiter.sv
// Randomized and directed bench for custom_ram_arbiter against a behavioural model.
// Build with CUSTOM_RAM_ARB_STARVE_EN to exercise starvation protection.
module tb_custom_ram_arbiter;

    localparam int AW = 14;
    localparam int MW = 4;
`ifdef CUSTOM_RAM_ARB_STARVE_EN
    localparam bit STARVE = 1'b1;
`else
    localparam bit STARVE = 1'b0;
`endif

    logic          clk;
    logic          rst_ni;
    logic          cust_req;
    logic [AW-1:0] cust_addr;
    logic          cust_gnt;
    logic          cust_rvalid;
    logic [31:0]   cust_rdata;
    logic          lsu_req;
    logic          lsu_we;
    logic [3:0]    lsu_be;
    logic [AW-1:0] lsu_addr;
    logic [31:0]   lsu_wdata;
    logic          lsu_gnt;
    logic          lsu_rvalid;
    logic [31:0]   lsu_rdata;
    logic          ram_req;
    logic          ram_we;
    logic [3:0]    ram_be;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;

    custom_ram_arbiter #(.ADDR_W(AW), .MAX_WAIT(MW)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .cust_req_i    (cust_req),
        .cust_addr_i   (cust_addr),
        .cust_gnt_o    (cust_gnt),
        .cust_rvalid_o (cust_rvalid),
        .cust_rdata_o  (cust_rdata),
        .lsu_req_i     (lsu_req),
        .lsu_we_i      (lsu_we),
        .lsu_be_i      (lsu_be),
        .lsu_addr_i    (lsu_addr),
        .lsu_wdata_i   (lsu_wdata),
        .lsu_gnt_o     (lsu_gnt),
        .lsu_rvalid_o  (lsu_rvalid),
        .lsu_rdata_o   (lsu_rdata),
        .ram_req_o     (ram_req),
        .ram_we_o      (ram_we),
        .ram_be_o      (ram_be),
        .ram_addr_o    (ram_addr),
        .ram_wdata_o   (ram_wdata),
        .ram_rdata_i   (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM: returns read data one cycle later, noise when idle.
    bit [31:0] mem [0:(1<<AW)-1];

    always @(posedge clk) begin
        if (ram_req) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++)
                    if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
                ram_rdata <= 32'h0;
            end else begin
                ram_rdata <= mem[ram_addr];
            end
        end else begin
            ram_rdata <= $urandom;
        end
    end

    int          n_chk;
    int          n_fail;
    int          lsu_wait;
    int          exp_own;
    logic [31:0] exp_rd;
    bit          obs_cust;
    bit          obs_lsu;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs are set at the negedge; checks the request phase, then the response.
    task automatic step();
        bit force_lsu;
        bit g_cust;
        bit g_lsu;
        #1;
        force_lsu = STARVE && lsu_req && (lsu_wait >= MW);
        g_cust    = cust_req && !force_lsu;
        g_lsu     = lsu_req && !g_cust;
        obs_cust  = cust_gnt;
        obs_lsu   = lsu_gnt;
        chk("cust_gnt", 32'(cust_gnt), 32'(g_cust));
        chk("lsu_gnt", 32'(lsu_gnt), 32'(g_lsu));
        chk("ram_req", 32'(ram_req), 32'(g_cust | g_lsu));
        if (g_cust) begin
            chk("ram_we_c", 32'(ram_we), 32'd0);
            chk("ram_be_c", 32'(ram_be), 32'hF);
            chk("ram_addr_c", 32'(ram_addr), 32'(cust_addr));
            exp_own = 1;
            exp_rd  = mem[cust_addr];
        end else if (g_lsu) begin
            chk("ram_we_l", 32'(ram_we), 32'(lsu_we));
            chk("ram_be_l", 32'(ram_be), 32'(lsu_be));
            chk("ram_addr_l", 32'(ram_addr), 32'(lsu_addr));
            chk("ram_wdata_l", ram_wdata, lsu_wdata);
            exp_own = 2;
            exp_rd  = lsu_we ? 32'h0 : mem[lsu_addr];
        end else begin
            chk("ram_idle", {ram_we, ram_be, 27'(ram_addr)}, 32'h0);
            chk("ram_wdata_idle", ram_wdata, 32'h0);
            exp_own = 0;
            exp_rd  = 32'h0;
        end
        @(posedge clk);
        if (lsu_req && !g_lsu) lsu_wait = (lsu_wait < MW) ? lsu_wait + 1 : MW;
        else lsu_wait = 0;
        #1;
        chk("cust_rvalid", 32'(cust_rvalid), 32'(exp_own == 1));
        chk("lsu_rvalid", 32'(lsu_rvalid), 32'(exp_own == 2));
        chk("cust_rdata", cust_rdata, (exp_own == 1) ? exp_rd : 32'h0);
        chk("lsu_rdata", lsu_rdata, (exp_own == 2) ? exp_rd : 32'h0);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        cust_req  = 1'b0;
        cust_addr = '0;
        lsu_req   = 1'b0;
        lsu_we    = 1'b0;
        lsu_be    = 4'h0;
        lsu_addr  = '0;
        lsu_wdata = 32'h0;
    endtask

    initial begin
        int first_lsu;
        int lsu_wins;
        n_chk    = 0;
        n_fail   = 0;
        lsu_wait = 0;
        exp_own  = 0;
        exp_rd   = 32'h0;
        mem[16]  = 32'hDEADBEEF;
        rst_ni   = 1'b0;
        idle_inputs();
        cust_req = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_cust_rvalid", 32'(cust_rvalid), 32'd0);
        chk("rst_lsu_rvalid", 32'(lsu_rvalid), 32'd0);
        chk("rst_cust_rdata", cust_rdata, 32'h0);
        @(negedge clk);
        rst_ni = 1'b1;

        // Custom read right after release.
        cust_addr = AW'(16);
        step();
        chk("cust_only_data", cust_rdata, 32'hDEADBEEF);
        chk("cust_only_lsu_rv", 32'(lsu_rvalid), 32'd0);
        cust_req = 1'b0;

        // LSU partial write at the top address.
        lsu_req   = 1'b1;
        lsu_we    = 1'b1;
        lsu_be    = 4'b0011;
        lsu_addr  = AW'(16'h3FFF);
        lsu_wdata = 32'h1234ABCD;
        step();
        chk("lsu_wr_rvalid", 32'(lsu_rvalid), 32'd1);
        idle_inputs();
        step();

        // Contention with an empty wait history.
        cust_req  = 1'b1;
        cust_addr = AW'(16);
        lsu_req   = 1'b1;
        lsu_addr  = AW'(16'h3FFF);
        step();
        chk("both_cust_wins", 32'(obs_cust), 32'd1);
        chk("both_lsu_held", 32'(obs_lsu), 32'd0);
        cust_req = 1'b0;
        step();
        chk("lsu_readback", lsu_rdata, 32'h0000ABCD);
        idle_inputs();
        step();

        // Custom hammers the port while the LSU waits.
        cust_req  = 1'b1;
        lsu_req   = 1'b1;
        lsu_addr  = AW'(5);
        first_lsu = 0;
        lsu_wins  = 0;
        for (int c = 1; c <= 100 && first_lsu == 0; c++) begin
            step();
            if (obs_lsu) begin
                first_lsu = c;
                lsu_wins++;
            end
        end
        if (STARVE) begin
            chk("starve_cycle", 32'(first_lsu), 32'd5);
            lsu_req = 1'b0;
            step();
            chk("cust_after_force", 32'(obs_cust), 32'd1);
        end else begin
            chk("never_lsu", 32'(lsu_wins), 32'd0);
        end
        idle_inputs();
        step();

        // Reset lands in the cycle after a custom grant.
        cust_req  = 1'b1;
        cust_addr = AW'(16);
        #1;
        chk("pre_rst_gnt", 32'(cust_gnt), 32'd1);
        @(posedge clk);
        #1;
        rst_ni = 1'b0;
        #1;
        chk("rst_drop_rvalid", 32'(cust_rvalid), 32'd0);
        chk("rst_drop_rdata", cust_rdata, 32'h0);
        @(negedge clk);
        cust_req = 1'b0;
        @(negedge clk);
        rst_ni   = 1'b1;
        lsu_wait = 0;
        @(posedge clk);
        #1;
        chk("post_rst_cust_rv", 32'(cust_rvalid), 32'd0);
        chk("post_rst_lsu_rv", 32'(lsu_rvalid), 32'd0);
        @(negedge clk);

        // Random traffic; a pending request stays stable until granted.
        obs_cust = 1'b0;
        obs_lsu  = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!cust_req || obs_cust) begin
                cust_req  = 1'($urandom_range(0, 1));
                cust_addr = AW'($urandom_range(0, 15));
            end
            if (!lsu_req || obs_lsu) begin
                lsu_req   = 1'($urandom_range(0, 1));
                lsu_we    = 1'($urandom_range(0, 1));
                lsu_be    = 4'($urandom);
                lsu_addr  = AW'($urandom_range(0, 15));
                lsu_wdata = $urandom;
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
